dmem_bridge: RTL
================

# dmem_bridge

Memory-stage bridge between the pipelined datapath and a word-addressed data bus with valid/ready request and valid response channels. It takes the M-stage address, write data and load/store controls, runs one bus transaction per access and returns the load data. While a transaction is in flight it asserts a stall to the hazard unit. Each access occupies the M stage for a bounded number of cycles, set by a response timeout.

## Interface
- TIMEOUT, default 255: maximum cycles spent in WAIT before the access is aborted (1..65535).
- clk  in  1: pipeline clock; all state changes on the rising edge.
- rst  in  1: synchronous, active-high reset.
- mem_readM  in  1: M-stage load (driven from mem_to_regM).
- mem_writeM  in  1: M-stage store.
- addrM  in  32: byte address (alu_outM).
- wdataM  in  32: store data (write_dataM).
- read_dataM  out  32: load data. Valid only in the DONE cycle, otherwise 0.
- stallM  out  1: freeze all pipeline registers this cycle.
- errM  out  1: one-cycle pulse in DONE when the access was misaligned or timed out.
- bus_req_valid  out  1: request valid.
- bus_req_ready  in  1: request accepted when valid & ready.
- bus_req_we  out  1: 1 = write, 0 = read.
- bus_req_addr  out  30: word address (addrM[31:2]).
- bus_req_wdata  out  32: write data.
- bus_rsp_valid  in  1: response/write-ack valid, single cycle.
- bus_rsp_data  in  32: read data, sampled when bus_rsp_valid is high.

## Operation
- Access = mem_readM | mem_writeM. If both are high, the access is treated as a write.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No access: stallM = 0.
  - Access with addrM[1:0] == 0: stallM = 1. Latch addr/we/wdata into the bus_req registers, then go to REQ.
  - Access with addrM[1:0] != 0: stallM = 1, go to DONE with data = 0 and the error flag set. No bus activity.
- REQ: bus_req_valid = 1 and stallM = 1. The request fields are held stable until accepted. On bus_req_ready, go to WAIT and clear the timeout counter. There is no timeout in REQ.
- WAIT: stallM = 1 and the counter increments each cycle.
  - bus_rsp_valid: capture bus_rsp_data (or 0 for a write), go to DONE.
  - Otherwise, when counter == TIMEOUT-1: capture 0, set the error flag, go to DONE.
  - If a response arrives in the same cycle as the timeout, the response wins.
- DONE: stallM = 0 and read_dataM = captured data. errM = error flag. Always go to IDLE next cycle.
- The pipeline advances M whenever stallM = 0, so the instruction leaves M at the end of DONE and is never reissued.
- bus_rsp_valid is ignored in IDLE, REQ and DONE. The bus guarantees a response arrives no earlier than the cycle after acceptance.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing
- Reset values: state = IDLE, stallM = 0 (M stage empty after reset), read_dataM = 0, errM = 0, bus_req_valid = 0, bus_req_we = 0, bus_req_addr = 0, bus_req_wdata = 0, counter = 0.
- Combinational outputs: stallM and read_dataM are decoded from the state and inputs in the same cycle, with no registered lag.
- Bus-side outputs (bus_req_*): all registered.
- Minimum access: 4 cycles in M (IDLE, REQ with ready, WAIT with response, DONE). Stall is asserted for 3 cycles.
- Misaligned access: 2 cycles (IDLE, DONE).
- Timeout path: 2 + (cycles in REQ) + TIMEOUT cycles.
- Reset mid-transaction: return to IDLE on the next edge with bus_req_valid low. A late response is ignored.

## Structure
- Package dmem_bridge_pkg holds the state enum (IDLE/REQ/WAIT/DONE) and the WORD_W = 32 and ADDR_W = 30 constants.
- The captured-data register reuses the existing flopenr.
- No further sub-modules. The FSM, counter and request registers live in one module.

## Test plan
- Load, ready immediate, response next cycle with 0xDEADBEEF at addr 0x100:
  - bus_req_addr = 0x40, we = 0.
  - stallM high for exactly 3 cycles.
  - read_dataM = 0xDEADBEEF in the DONE cycle, errM = 0.
- Store 0x12345678 to 0x204 with ready held low for 5 cycles:
  - valid/addr/wdata stay stable through all 5 cycles.
  - After the ack, DONE with read_dataM = 0 and stallM dropping once.
- Load from 0x103:
  - No bus_req_valid.
  - stallM for 1 cycle, then errM pulse with read_dataM = 0.
- TIMEOUT = 4, request accepted, no response:
  - DONE exactly 4 cycles after acceptance, errM = 1, read_dataM = 0.
  - Repeat with the response on the 4th WAIT cycle: data returned, errM = 0.
- rst asserted during WAIT, response arriving 2 cycles later:
  - state IDLE, all outputs at reset values, response ignored.
- Two back-to-back loads:
  - Second request starts in the cycle after DONE.
  - No duplicate transaction for the first load.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and widths for the M-stage data-memory bridge.
package dmem_bridge_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// Word-addressed data bus: valid/ready request channel plus single-cycle response.
interface dmem_bridge_if;
    import dmem_bridge_pkg::*;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_req_we;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [WORD_W-1:0] bus_req_wdata;
    logic              bus_rsp_valid;
    logic [WORD_W-1:0] bus_rsp_data;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data
    );

endinterface

// File: rtl/dmem_bridge_flopenr.sv
// Enabled flip-flop with synchronous active-high reset.
module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage bridge: one bus transaction per load/store, stalling the pipeline
// until the response (or a timeout) and presenting the result for one cycle.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_readM,
    input  logic              mem_writeM,
    input  logic [WORD_W-1:0] addrM,
    input  logic [WORD_W-1:0] wdataM,
    output logic [WORD_W-1:0] read_dataM,
    output logic              stallM,
    output logic              errM,
    dmem_bridge_if.master     bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t            state_r;
    state_t            next_state_s;
    logic [CW-1:0]     cnt_r;
    logic              err_r;
    logic              req_valid_r;
    logic              req_we_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [WORD_W-1:0] req_wdata_r;
    logic [WORD_W-1:0] cap_data_r;

    logic              access_s;
    logic              misaligned_s;
    logic              start_s;
    logic              accept_s;
    logic              rsp_s;
    logic              timeout_s;
    logic              cap_en_s;
    logic [WORD_W-1:0] cap_d_s;

    assign access_s     = mem_readM | mem_writeM;
    assign misaligned_s = (addrM[1:0] != 2'b00);
    assign start_s      = (state_r == IDLE) && access_s;
    assign accept_s     = (state_r == REQ) && bus.bus_req_ready;
    // A response in the timeout cycle takes priority over the abort.
    assign rsp_s        = (state_r == WAIT) && bus.bus_rsp_valid;
    assign timeout_s    = (state_r == WAIT) && !bus.bus_rsp_valid && (cnt_r == CNT_LAST);
    assign cap_en_s     = start_s || rsp_s || timeout_s;
    assign cap_d_s      = (rsp_s && !req_we_r) ? bus.bus_rsp_data : {WORD_W{1'b0}};

    assign bus.bus_req_valid = req_valid_r;
    assign bus.bus_req_we    = req_we_r;
    assign bus.bus_req_addr  = req_addr_r;
    assign bus.bus_req_wdata = req_wdata_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s && misaligned_s) begin
                    next_state_s = DONE;
                end else if (access_s) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.bus_req_ready) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT: begin
                if (rsp_s || timeout_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Pipeline-side outputs, decoded without lag from state and inputs.
    always_comb begin
        stallM     = 1'b0;
        read_dataM = {WORD_W{1'b0}};
        errM       = 1'b0;
        case (state_r)
            IDLE:    stallM = access_s;
            REQ:     stallM = 1'b1;
            WAIT:    stallM = 1'b1;
            DONE: begin
                read_dataM = cap_data_r;
                errM       = err_r;
            end
            default: stallM = 1'b0;
        endcase
    end

    // Response timeout counter: cleared on acceptance, saturating in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == WAIT) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Error flag: misaligned at entry, or timed out in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start_s) begin
            err_r <= misaligned_s;
        end else if (rsp_s || timeout_s) begin
            err_r <= timeout_s;
        end else begin
            err_r <= err_r;
        end
    end

    // Request registers: latched at start, held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_r <= 1'b0;
            req_we_r    <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_wdata_r <= {WORD_W{1'b0}};
        end else if (start_s && !misaligned_s) begin
            req_valid_r <= 1'b1;
            req_we_r    <= mem_writeM;
            req_addr_r  <= addrM[WORD_W-1:2];
            req_wdata_r <= wdataM;
        end else if (accept_s) begin
            req_valid_r <= 1'b0;
            req_we_r    <= req_we_r;
            req_addr_r  <= req_addr_r;
            req_wdata_r <= req_wdata_r;
        end else begin
            req_valid_r <= req_valid_r;
            req_we_r    <= req_we_r;
            req_addr_r  <= req_addr_r;
            req_wdata_r <= req_wdata_r;
        end
    end

    flopenr #(.WIDTH(WORD_W)) u_cap_data (
        .clk   (clk),
        .reset (rst),
        .en    (cap_en_s),
        .d     (cap_d_s),
        .q     (cap_data_r)
    );

endmodule
